// File: rtl/fxp2fp_block.sv
// fxp2fp_block: frame buffer plus converter from signed-magnitude Q8.23
// samples to IEEE-754 single precision, streamed out over valid/ready.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a buffered sample that has not been delivered
// NORM   | read buffer[rd_cnt], capture sign, magnitude, leading-one index
// OUT    | fp_o/fp_valid_o presented and held until fp_ready_i
module fxp2fp_block #(
    parameter int data_size      = 32,
    parameter int number_of_data = 10,
    parameter int frac_bits      = 23
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [data_size-1:0] fxp_i,
    input  logic                 fxp_valid_i,
    output logic                 fxp_ready_o,
    output logic [data_size-1:0] fp_o,
    output logic                 fp_valid_o,
    input  logic                 fp_ready_i,
    output logic                 frame_done_o
);

    localparam int              CW       = $clog2(number_of_data + 1);
    localparam logic [CW-1:0]   FRAME_N  = CW'(number_of_data);
    // exponent = p - frac_bits + 127, with p the leading-one index
    localparam logic [7:0]      EXP_BIAS = 8'(127 - frac_bits);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]          rd_cnt_q, rd_cnt_d;
    logic                   sign_q, sign_d;
    logic [30:0]            mag_q, mag_d;
    logic [4:0]             lead_q, lead_d;
    logic                   zero_q, zero_d;
    logic                   fp_valid_q, fp_valid_d;
    logic                   frame_done_q, frame_done_d;

    logic [data_size-1:0]   buffer_q [number_of_data];

    logic                   wr_en;
    logic                   out_hs;
    logic [data_size-1:0]   rd_word;
    logic [4:0]             lead_idx;
    logic [30:0]            mag_low;
    logic [22:0]            mant;
    logic [7:0]             expo;

    assign fxp_ready_o  = (wr_cnt_q < FRAME_N);
    assign wr_en        = fxp_valid_i && fxp_ready_o;
    assign out_hs       = fp_valid_q && fp_ready_i;
    assign fp_valid_o   = fp_valid_q;
    assign frame_done_o = frame_done_q;

    // Sample storage; contents are meaningless once the counters are cleared.
    always_ff @(posedge clock_i) begin
        if (wr_en) begin
            buffer_q[wr_cnt_q] <= fxp_i;
        end
    end

    // Read port and leading-one search on the magnitude being normalised.
    always_comb begin
        rd_word  = buffer_q[rd_cnt_q];
        lead_idx = 5'd0;
        for (int i = 0; i < 31; i++) begin
            if (rd_word[i]) begin
                lead_idx = 5'(i);
            end
        end
    end

    // Next-state logic for the FSM, the frame counters and the frame pulse.
    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        sign_d       = sign_q;
        mag_d        = mag_q;
        lead_d       = lead_q;
        zero_d       = zero_q;
        fp_valid_d   = fp_valid_q;
        frame_done_d = 1'b0;

        if (wr_en) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (rd_cnt_q < wr_cnt_q) begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                sign_d     = rd_word[31];
                mag_d      = rd_word[30:0];
                lead_d     = lead_idx;
                zero_d     = (rd_word[30:0] == 31'd0);
                fp_valid_d = 1'b1;
                state_d    = ST_OUT;
            end
            ST_OUT: begin
                if (out_hs) begin
                    fp_valid_d = 1'b0;
                    rd_cnt_d   = rd_cnt_q + 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The last delivery of a frame parks rd_cnt at FRAME_N for one cycle;
        // the wrap happens on the following edge. wr_cnt is necessarily full
        // here, so no write can collide with the clear.
        if (rd_cnt_q == FRAME_N) begin
            rd_cnt_d     = '0;
            wr_cnt_d     = '0;
            frame_done_d = 1'b1;
        end
    end

    // State and control registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            sign_q       <= 1'b0;
            mag_q        <= '0;
            lead_q       <= '0;
            zero_q       <= 1'b1;
            fp_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            sign_q       <= sign_d;
            mag_q        <= mag_d;
            lead_q       <= lead_d;
            zero_q       <= zero_d;
            fp_valid_q   <= fp_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Pack the captured fields; a pure function of registers, so fp_o holds
    // steady for as long as the OUT state stalls.
    always_comb begin
        mag_low = mag_q & ~(31'd1 << lead_q);
        if (lead_q > 5'd23) begin
            mant = 23'(mag_low >> (lead_q - 5'd23));
        end else begin
            mant = 23'(mag_low << (5'd23 - lead_q));
        end
        expo = {3'b000, lead_q} + EXP_BIAS;
        fp_o = zero_q ? '0 : {sign_q, expo, mant};
    end

endmodule

// File: tb/tb_fxp2fp_block.sv
// tb_fxp2fp_block: scoreboard bench for fxp2fp_block.
module tb_fxp2fp_block;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [31:0] fxp_i = '0;
    logic        fxp_valid_i = 1'b0;
    logic        fxp_ready_o;
    logic [31:0] fp_o;
    logic        fp_valid_o;
    logic        fp_ready_i = 1'b1;
    logic        frame_done_o;

    fxp2fp_block #(
        .data_size(32),
        .number_of_data(10),
        .frac_bits(23)
    ) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .fxp_i(fxp_i),
        .fxp_valid_i(fxp_valid_i),
        .fxp_ready_o(fxp_ready_o),
        .fp_o(fp_o),
        .fp_valid_o(fp_valid_o),
        .fp_ready_i(fp_ready_i),
        .frame_done_o(frame_done_o)
    );

    always #5 clock_i = ~clock_i;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];
    int          tot_acc = 0;
    int          fd_count = 0;
    int          frame_hs = 0;
    int          fd_wait = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_fp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: value = m * 2^-23; find p with 2^p <= m < 2^(p+1), then the
    // fraction is floor(m * 2^23 / 2^p) - 2^23 (truncation toward zero).
    function automatic logic [31:0] ref_fp(input logic [31:0] x);
        longint m;
        longint frac;
        int     p;
        int     e;
        logic [7:0]  e8;
        logic [22:0] f23;
        m = longint'(x[30:0]);
        if (m == 0) return 32'h0;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        frac = ((m << 23) >> p) - (longint'(1) << 23);
        e    = p - 23 + 127;
        e8   = e[7:0];
        f23  = frac[22:0];
        return {x[31], e8, f23};
    endfunction

    function automatic logic [31:0] rand_fxp();
        logic [31:0] r;
        r = $urandom;
        r[30:0] = r[30:0] >> $urandom_range(0, 31);
        if ($urandom_range(0, 15) == 0) r[30:0] = '0;
        return r;
    endfunction

    // Monitor: records accepted inputs, scores outputs, watches stalls and frame pulses.
    always @(negedge clock_i) begin
        logic exp_fd;
        exp_fd = (fd_wait == 1);
        check("frame_done", {31'd0, frame_done_o}, {31'd0, exp_fd});
        if (frame_done_o) begin
            check("done_vs_valid", {31'd0, fp_valid_o}, 32'd0);
            check("ready_after_done", {31'd0, fxp_ready_o}, 32'd1);
            fd_count++;
        end
        if (fd_wait > 0) fd_wait--;
        if (prev_stall) begin
            check("stall_valid", {31'd0, fp_valid_o}, 32'd1);
            check("stall_data", fp_o, prev_fp);
        end
        if (reset_i) begin
            sb_q.delete();
            frame_hs   = 0;
            fd_wait    = 0;
            prev_stall = 1'b0;
        end else begin
            if (fxp_valid_i && fxp_ready_o) begin
                sb_q.push_back(ref_fp(fxp_i));
                tot_acc++;
            end
            if (fp_valid_o && fp_ready_i) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got %h expected no output", fp_o);
                end else begin
                    check("fp_o", fp_o, sb_q.pop_front());
                end
                frame_hs++;
                if (frame_hs == 10) begin
                    frame_hs = 0;
                    fd_wait  = 2;
                end
            end
            prev_stall = fp_valid_o && !fp_ready_i;
            prev_fp    = fp_o;
        end
    end

    task automatic do_reset();
        @(posedge clock_i); #1;
        reset_i = 1'b1;
        @(posedge clock_i); #1;
        reset_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock_i); #1;
        end
    endtask

    task automatic send_lat(input logic [31:0] x, input logic [31:0] exp);
        @(posedge clock_i); #1;
        fxp_i       = x;
        fxp_valid_i = 1'b1;
        check("lat_ready", {31'd0, fxp_ready_o}, 32'd1);
        @(posedge clock_i); #1;
        fxp_valid_i = 1'b0;
        check("lat_e0", {31'd0, fp_valid_o}, 32'd0);
        @(posedge clock_i); #1;
        check("lat_e1", {31'd0, fp_valid_o}, 32'd0);
        @(posedge clock_i); #1;
        check("lat_e2", {31'd0, fp_valid_o}, 32'd1);
        check("direct_fp", fp_o, exp);
    endtask

    task automatic wait_drain(input int limit, input bit tog);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(posedge clock_i); #1;
            if (tog) fp_ready_i = 1'($urandom_range(0, 1));
            if (sb_q.size() == 0 && !fp_valid_o) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", sb_q.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] dir_in  [8];
        logic [31:0] dir_exp [8];
        logic [31:0] r;
        int          base_acc;
        int          base_fd;

        dir_in[0] = 32'h00800000; dir_exp[0] = 32'h3F800000;
        dir_in[1] = 32'h00400000; dir_exp[1] = 32'h3F000000;
        dir_in[2] = 32'h01800000; dir_exp[2] = 32'h40400000;
        dir_in[3] = 32'h81000000; dir_exp[3] = 32'hC0000000;
        dir_in[4] = 32'h00000000; dir_exp[4] = 32'h00000000;
        dir_in[5] = 32'h80000000; dir_exp[5] = 32'h00000000;
        dir_in[6] = 32'h7FFFFFFF; dir_exp[6] = 32'h437FFFFF;
        dir_in[7] = 32'h00000001; dir_exp[7] = 32'h34000000;

        // Reset values
        idle(3);
        reset_i = 1'b0;
        check("rst_ready", {31'd0, fxp_ready_o}, 32'd1);
        check("rst_valid", {31'd0, fp_valid_o}, 32'd0);
        check("rst_fp", fp_o, 32'd0);
        check("rst_done", {31'd0, frame_done_o}, 32'd0);

        // Directed conversions and extremes, completed to a full frame
        fp_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) send_lat(dir_in[i], dir_exp[i]);
        for (int i = 0; i < 2; i++) begin
            r = rand_fxp();
            send_lat(r, ref_fp(r));
        end
        idle(6);

        // Full frame under backpressure, then drain with a second frame following
        do_reset();
        fp_ready_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock_i); #1;
            fxp_valid_i = 1'b1;
            fxp_i       = rand_fxp();
            if (i >= 10) check("full_ready", {31'd0, fxp_ready_o}, 32'd0);
        end
        @(posedge clock_i); #1;
        fxp_valid_i = 1'b0;
        check("accepted_cnt", sb_q.size(), 32'd10);
        check("full_ready_hold", {31'd0, fxp_ready_o}, 32'd0);
        idle(6);
        fp_ready_i = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock_i); #1;
            fxp_valid_i = 1'b1;
            fxp_i       = rand_fxp();
        end
        fxp_valid_i = 1'b0;
        wait_drain(400, 1'b0);
        idle(6);

        // Reset while stalled in OUT with more samples pending
        do_reset();
        fp_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock_i); #1;
            fxp_valid_i = 1'b1;
            fxp_i       = rand_fxp();
        end
        @(posedge clock_i); #1;
        fxp_valid_i = 1'b0;
        for (int i = 0; i < 20 && !fp_valid_o; i++) begin
            @(posedge clock_i); #1;
        end
        check("pre_rst_valid", {31'd0, fp_valid_o}, 32'd1);
        do_reset();
        check("mid_rst_valid", {31'd0, fp_valid_o}, 32'd0);
        check("mid_rst_ready", {31'd0, fxp_ready_o}, 32'd1);
        fp_ready_i = 1'b1;
        idle(15);

        // Random traffic with toggling ready over three frames
        base_acc = tot_acc;
        base_fd  = fd_count;
        for (int i = 0; i < 3000 && (tot_acc - base_acc) < 30; i++) begin
            @(posedge clock_i); #1;
            fp_ready_i = 1'($urandom_range(0, 1));
            if ((tot_acc - base_acc) < 30) begin
                fxp_valid_i = ($urandom_range(0, 3) != 0);
                fxp_i       = rand_fxp();
            end
            if ((tot_acc - base_acc) >= 30) fxp_valid_i = 1'b0;
        end
        @(posedge clock_i); #1;
        fxp_valid_i = 1'b0;
        check("rand_accepted", tot_acc - base_acc, 32'd30);
        wait_drain(2000, 1'b1);
        fp_ready_i = 1'b1;
        idle(6);
        check("rand_frames", fd_count - base_fd, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
